// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: RV32I opcode/funct encodings and ALU operand-select codes.
package rv32_ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRA     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [1:0] MUX_REG_REG = 2'b00;
  localparam logic [1:0] MUX_REG_IMM = 2'b01;
  localparam logic [1:0] MUX_PC_IMM  = 2'b10;
endpackage

// File: rtl/alu_core.sv
// alu_core: EX-stage ALU with fixed-priority operation select and branch-target override.
module alu_core #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              add_i,
  input  logic              sub_i,
  input  logic              addi_i,
  input  logic              and_i,
  input  logic              or_i,
  input  logic              sll_i,
  input  logic              sra_i,
  input  logic              sw_i,
  input  logic              lw_i,
  input  logic              branch_i,
  output logic [DATA_W-1:0] result_o
);
  logic [DATA_W-1:0] sum, diff, shl, shr;
  logic [4:0]        shamt;
  assign shamt = b_i[4:0];
  assign sum   = a_i + b_i;
  assign diff  = a_i - b_i;
  assign shl   = a_i << shamt;
  assign shr   = DATA_W'($signed(a_i) >>> shamt);
  // A taken branch reuses the adder for the target, regardless of ex_* controls.
  always_comb begin
    result_o = (branch_i || add_i || addi_i || lw_i || sw_i) ? sum :
               sub_i ? diff :
               and_i ? (a_i & b_i) :
               or_i  ? (a_i | b_i) :
               sll_i ? shl :
               sra_i ? shr : '0;
  end
endmodule

// File: rtl/alu_ctrl_ex_mem.sv
// alu_ctrl_ex_mem: RV32I control decoder, EX-stage ALU and EX/MEM result register.
module alu_ctrl_ex_mem
  import rv32_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       instruction,
  output logic              add_control,
  output logic              sub_control,
  output logic              and_control,
  output logic              or_control,
  output logic              addi_control,
  output logic              sll_control,
  output logic              sra_control,
  output logic              branch_control,
  output logic              sw_control,
  output logic              lw_control,
  output logic [1:0]        mux_control_signal,
  output logic              read_data_memory,
  output logic              write_data_memory,
  output logic              write_destination_reg,
  input  logic [DATA_W-1:0] a_alu,
  input  logic [DATA_W-1:0] b_alu,
  input  logic              ex_add,
  input  logic              ex_sub,
  input  logic              ex_addi,
  input  logic              ex_and,
  input  logic              ex_or,
  input  logic              ex_sll,
  input  logic              ex_sra,
  input  logic              ex_sw,
  input  logic              ex_lw,
  input  logic              branch_taken_decision,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] alu_result_mem
);
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_r, r_any, unused_fields;
  logic [DATA_W-1:0] alu_result_mem_d, alu_result_mem_q;
  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};
  assign is_r = opcode == OP_R;
  always_comb begin
    add_control    = is_r && funct3 == F3_ADD_SUB && funct7 == F7_BASE;
    sub_control    = is_r && funct3 == F3_ADD_SUB && funct7 == F7_ALT;
    sll_control    = is_r && funct3 == F3_SLL && funct7 == F7_BASE;
    sra_control    = is_r && funct3 == F3_SRA && funct7 == F7_ALT;
    or_control     = is_r && funct3 == F3_OR && funct7 == F7_BASE;
    and_control    = is_r && funct3 == F3_AND && funct7 == F7_BASE;
    addi_control   = opcode == OP_IMM && funct3 == F3_ADDI;
    lw_control     = opcode == OP_LOAD && funct3 == F3_WORD;
    sw_control     = opcode == OP_STORE && funct3 == F3_WORD;
    branch_control = opcode == OP_BRANCH && funct3 == F3_BEQ;
    r_any = add_control || sub_control || sll_control || sra_control || or_control || and_control;
    // Unlisted encodings fall through to MUX_REG_REG with every enable low.
    mux_control_signal = branch_control ? MUX_PC_IMM :
                         (addi_control || lw_control || sw_control) ? MUX_REG_IMM : MUX_REG_REG;
    read_data_memory      = lw_control;
    write_data_memory     = sw_control;
    write_destination_reg = r_any || addi_control || lw_control;
  end
  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a_i      (a_alu),
    .b_i      (b_alu),
    .add_i    (ex_add),
    .sub_i    (ex_sub),
    .addi_i   (ex_addi),
    .and_i    (ex_and),
    .or_i     (ex_or),
    .sll_i    (ex_sll),
    .sra_i    (ex_sra),
    .sw_i     (ex_sw),
    .lw_i     (ex_lw),
    .branch_i (branch_taken_decision),
    .result_o (alu_result)
  );
  assign alu_result_mem_d = alu_result;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) alu_result_mem_q <= '0;
    else          alu_result_mem_q <= alu_result_mem_d;
  end
  assign alu_result_mem = alu_result_mem_q;
endmodule

// File: tb/tb_alu_ctrl_ex_mem.sv
// tb_alu_ctrl_ex_mem: directed vectors with a scoreboard queue drained by a negedge monitor.
module tb_alu_ctrl_ex_mem;
  logic        clock, reset_n;
  logic [31:0] instruction, a_alu, b_alu, alu_result, alu_result_mem;
  logic add_control, sub_control, and_control, or_control, addi_control, sll_control;
  logic sra_control, branch_control, sw_control, lw_control;
  logic [1:0] mux_control_signal;
  logic read_data_memory, write_data_memory, write_destination_reg;
  logic ex_add, ex_sub, ex_addi, ex_and, ex_or, ex_sll, ex_sra, ex_sw, ex_lw, branch_taken_decision;

  alu_ctrl_ex_mem #(.DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .instruction(instruction),
    .add_control(add_control), .sub_control(sub_control), .and_control(and_control),
    .or_control(or_control), .addi_control(addi_control), .sll_control(sll_control),
    .sra_control(sra_control), .branch_control(branch_control), .sw_control(sw_control),
    .lw_control(lw_control), .mux_control_signal(mux_control_signal),
    .read_data_memory(read_data_memory), .write_data_memory(write_data_memory),
    .write_destination_reg(write_destination_reg), .a_alu(a_alu), .b_alu(b_alu),
    .ex_add(ex_add), .ex_sub(ex_sub), .ex_addi(ex_addi), .ex_and(ex_and), .ex_or(ex_or),
    .ex_sll(ex_sll), .ex_sra(ex_sra), .ex_sw(ex_sw), .ex_lw(ex_lw),
    .branch_taken_decision(branch_taken_decision),
    .alu_result(alu_result), .alu_result_mem(alu_result_mem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;

  // One-hot order: add,sub,and,or,addi,sll,sra,branch,sw,lw
  localparam logic [9:0] O_ADD = 10'b1000000000, O_SUB = 10'b0100000000, O_AND = 10'b0010000000;
  localparam logic [9:0] O_OR  = 10'b0001000000, O_ADDI = 10'b0000100000, O_SLL = 10'b0000010000;
  localparam logic [9:0] O_SRA = 10'b0000001000, O_BR = 10'b0000000100, O_SW = 10'b0000000010;
  localparam logic [9:0] O_LW  = 10'b0000000001, O_NONE = 10'b0;

  logic [31:0] dec_vec, act;
  assign dec_vec = {17'b0, add_control, sub_control, and_control, or_control, addi_control,
                    sll_control, sra_control, branch_control, sw_control, lw_control,
                    mux_control_signal, read_data_memory, write_data_memory, write_destination_reg};

  function automatic logic [31:0] dx(input logic [9:0] oh, input logic [1:0] mux,
                                     input logic rd, input logic wr, input logic wd);
    return {17'b0, oh, mux, rd, wr, wd};
  endfunction

  always @(negedge clock) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      act = cur.kind == 0 ? dec_vec : cur.kind == 1 ? alu_result : alu_result_mem;
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic expect_v(input string nm, input int kind, input logic [31:0] e);
    exp_t x;
    x.name = nm;
    x.kind = kind;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic dec(input string nm, input logic [31:0] ins, input logic [31:0] e);
    instruction = ins;
    expect_v(nm, 0, e);
    next_cycle();
  endtask

  // ex bits in priority order: add,addi,lw,sw,sub,and,or,sll,sra
  task automatic drive_alu(input logic [8:0] ex, input logic br, input logic [31:0] a, input logic [31:0] b);
    {ex_add, ex_addi, ex_lw, ex_sw, ex_sub, ex_and, ex_or, ex_sll, ex_sra} = ex;
    branch_taken_decision = br;
    a_alu = a;
    b_alu = b;
  endtask

  task automatic alu(input string nm, input logic [8:0] ex, input logic br,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    drive_alu(ex, br, a, b);
    expect_v(nm, 1, e);
    next_cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    instruction = 32'h0;
    drive_alu(9'b0, 1'b0, 32'h0, 32'h0);
    #1;
    expect_v("reset_mem", 2, 32'h0);
    next_cycle();
    reset_n = 1'b1;
    dec("dec_add",      32'h00B50533, dx(O_ADD, 2'b00, 1'b0, 1'b0, 1'b1));
    dec("dec_sub",      32'h403100B3, dx(O_SUB, 2'b00, 1'b0, 1'b0, 1'b1));
    dec("dec_sll",      32'h003110B3, dx(O_SLL, 2'b00, 1'b0, 1'b0, 1'b1));
    dec("dec_sra",      32'h403150B3, dx(O_SRA, 2'b00, 1'b0, 1'b0, 1'b1));
    dec("dec_or",       32'h003160B3, dx(O_OR,  2'b00, 1'b0, 1'b0, 1'b1));
    dec("dec_and",      32'h003170B3, dx(O_AND, 2'b00, 1'b0, 1'b0, 1'b1));
    dec("dec_addi",     32'h00510093, dx(O_ADDI, 2'b01, 1'b0, 1'b0, 1'b1));
    dec("dec_lw",       32'h0080A283, dx(O_LW,  2'b01, 1'b1, 1'b0, 1'b1));
    dec("dec_sw",       32'h0020A023, dx(O_SW,  2'b01, 1'b0, 1'b1, 1'b0));
    dec("dec_beq",      32'h00208463, dx(O_BR,  2'b10, 1'b0, 1'b0, 1'b0));
    dec("dec_allones",  32'hFFFFFFFF, dx(O_NONE, 2'b00, 1'b0, 1'b0, 1'b0));
    dec("dec_sll_f7",   32'h403110B3, dx(O_NONE, 2'b00, 1'b0, 1'b0, 1'b0));
    dec("dec_srl",      32'h003150B3, dx(O_NONE, 2'b00, 1'b0, 1'b0, 1'b0));
    dec("dec_lb",       32'h00008283, dx(O_NONE, 2'b00, 1'b0, 1'b0, 1'b0));
    alu("alu_add",      9'b100000000, 1'b0, 32'h3, 32'h4, 32'h7);
    alu("alu_addi_ovf", 9'b010000000, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0);
    alu("alu_lw",       9'b001000000, 1'b0, 32'h1000, 32'h8, 32'h1008);
    alu("alu_sw",       9'b000100000, 1'b0, 32'h2000, 32'hFFFFFFFC, 32'h1FFC);
    alu("alu_and",      9'b000001000, 1'b0, 32'hF0F0, 32'hFF00, 32'hF000);
    alu("alu_or",       9'b000000100, 1'b0, 32'hF0F0, 32'h0F0F, 32'hFFFF);
    alu("alu_sll",      9'b000000010, 1'b0, 32'h1, 32'h23, 32'h8);
    alu("alu_sra_neg",  9'b000000001, 1'b0, 32'h80000000, 32'h4, 32'hF8000000);
    alu("alu_sra_pos",  9'b000000001, 1'b0, 32'h70000000, 32'hFFFFFFE4, 32'h07000000);
    alu("alu_none",     9'b000000000, 1'b0, 32'h5, 32'h6, 32'h0);
    alu("alu_br_and",   9'b000001000, 1'b1, 32'h10, 32'h20, 32'h30);
    alu("alu_br_only",  9'b000000000, 1'b1, 32'h1, 32'h2, 32'h3);
    alu("pri_add_sub",  9'b100010000, 1'b0, 32'h5, 32'h7, 32'hC);
    alu("pri_sw_sub",   9'b000110000, 1'b0, 32'h5, 32'h7, 32'hC);
    alu("pri_sub_and",  9'b000011000, 1'b0, 32'h5, 32'h7, 32'hFFFFFFFE);
    alu("pri_and_or",   9'b000001100, 1'b0, 32'hF0F0, 32'h0F0F, 32'h0);
    alu("pri_or_sll",   9'b000000110, 1'b0, 32'h1, 32'h4, 32'h5);
    alu("pri_sll_sra",  9'b000000011, 1'b0, 32'h80000000, 32'h1, 32'h0);
    drive_alu(9'b000010000, 1'b0, 32'h5, 32'h7);
    expect_v("sub_comb", 1, 32'hFFFFFFFE);
    next_cycle();
    expect_v("sub_mem", 2, 32'hFFFFFFFE);
    drive_alu(9'b100000000, 1'b0, 32'h1000, 32'h234);
    next_cycle();
    expect_v("mem_1234", 2, 32'h1234);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    expect_v("async_rst_mem", 2, 32'h0);
    expect_v("rst_comb_kept", 1, 32'h1234);
    next_cycle();
    expect_v("rst_hold_mem", 2, 32'h0);
    drive_alu(9'b000010000, 1'b0, 32'h5, 32'h7);
    reset_n = 1'b1;
    next_cycle();
    expect_v("post_rst_capture", 2, 32'hFFFFFFFE);
    next_cycle();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
